// File: rtl/fpu_pkg.sv
// Shared binary32 definitions for the FPU datapath: field widths, operand
// classes, divider states and the rounding / NaN helpers that the
// multiplier also uses.
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;
  localparam int QW     = 27;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [2:0] {
    ZERO,
    SUB,
    NORM,
    INF,
    NAN
  } fp_class_t;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    DIV,
    DENORM,
    ROUND
  } div_state_t;

  // Round-to-nearest-even: bump when above half, or exactly half with odd lsb.
  function automatic logic rne_inc(input logic lsb, input logic guard,
                                   input logic rnd, input logic sticky);
    return guard & (rnd | sticky | lsb);
  endfunction

  // Quiet-NaN payload: the larger of the two low payload fields.
  function automatic logic [21:0] nan_payload(input logic [21:0] pa,
                                              input logic [21:0] pb);
    return (pa > pb) ? pa : pb;
  endfunction

endpackage

// File: rtl/fpu_div_unpack.sv
// Operand unpack for the divider: classifies a binary32 magnitude and
// returns a normalized 24-bit significand with its effective exponent.
module fpu_div_unpack
  import fpu_pkg::*;
(
  input  logic [30:0]        mag,
  output fp_class_t          cls,
  output logic [23:0]        sig,
  output logic signed [9:0]  eff_exp
);

  logic [EXP_W-1:0]  exp_f;
  logic [FRAC_W-1:0] frac;
  logic [23:0]       raw;
  logic [4:0]        lzc;
  logic              found;

  assign exp_f = mag[30:23];
  assign frac  = mag[22:0];
  assign raw   = {(exp_f != '0), frac};

  // Decide which of the five operand classes this encoding belongs to.
  always_comb begin
    cls = NORM;
    if (exp_f == '0)
      cls = (frac == '0) ? ZERO : SUB;
    else if (exp_f == EXP_MAX)
      cls = (frac == '0) ? INF : NAN;
  end

  // Count leading zeros of the raw significand, MSB first.
  always_comb begin
    lzc   = 5'd0;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found) begin
        if (raw[i])
          found = 1'b1;
        else
          lzc = lzc + 5'd1;
      end
    end
  end

  // Subnormals are shifted up to a leading one and get exponent 1 - lzc.
  always_comb begin
    if (cls == SUB) begin
      sig     = raw << lzc;
      eff_exp = 10'sd1 - $signed({5'b00000, lzc});
    end else begin
      sig     = raw;
      eff_exp = $signed({2'b00, exp_f});
    end
  end

endmodule

// File: rtl/fpu_div_iter.sv
// Iterative radix-2 restoring binary32 divider, q = a / b, with a
// start/busy/done handshake and a fixed 31-cycle latency for all inputs.
module fpu_div_iter
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] q,
  output logic        div_by_zero
);

  div_state_t state, next_state;

  logic [31:0]        a_r, b_r;
  fp_class_t          cls_a, cls_b;
  logic [23:0]        sig_a, sig_b;
  logic signed [9:0]  eff_a, eff_b;

  logic               sign_r;
  logic signed [9:0]  e_r;
  logic [23:0]        mb_r;
  logic [25:0]        rem_r;
  logic [QW-1:0]      quo_r;
  logic [4:0]         cnt_r;
  logic               sticky_r;
  logic               special_r;
  logic [31:0]        special_q_r;
  logic               special_dbz_r;

  logic               spec_hit, spec_dbz;
  logic [31:0]        spec_q;
  logic               sign_w;

  logic               rem_ge;
  logic [25:0]        rem_sub;
  logic [QW-1:0]      quo_step;

  logic signed [9:0]  shift_full;
  logic [4:0]         sh_sat;
  logic [QW-1:0]      quo_dn, lost_mask;
  logic               lost;

  logic               inc;
  logic [32:0]        sum;
  logic               ovf;
  logic [31:0]        round_q;

  fpu_div_unpack u_unpack_a (.mag(a_r[30:0]), .cls(cls_a), .sig(sig_a), .eff_exp(eff_a));
  fpu_div_unpack u_unpack_b (.mag(b_r[30:0]), .cls(cls_b), .sig(sig_b), .eff_exp(eff_b));

  assign sign_w = a_r[31] ^ b_r[31];

  // Special-case result, resolved by priority: NaN, then infinity, then zero.
  always_comb begin
    spec_hit = 1'b0;
    spec_dbz = 1'b0;
    spec_q   = '0;
    if (cls_a == NAN || cls_b == NAN ||
        (cls_a == ZERO && cls_b == ZERO) || (cls_a == INF && cls_b == INF)) begin
      spec_hit = 1'b1;
      spec_q   = {1'b1, EXP_MAX, 1'b1, nan_payload(a_r[21:0], b_r[21:0])};
    end else if (cls_a == INF || cls_b == ZERO) begin
      spec_hit = 1'b1;
      spec_q   = {sign_w, EXP_MAX, 23'd0};
      spec_dbz = (cls_b == ZERO) && (cls_a == NORM || cls_a == SUB);
    end else if (cls_a == ZERO || cls_b == INF) begin
      spec_hit = 1'b1;
      spec_q   = {sign_w, 8'h00, 23'd0};
    end
  end

  // One restoring step: subtract the divisor when it fits, emit one quotient bit.
  always_comb begin
    rem_ge   = (rem_r >= {2'b00, mb_r});
    rem_sub  = rem_ge ? (rem_r - {2'b00, mb_r}) : rem_r;
    quo_step = {quo_r[QW-2:0], rem_ge};
  end

  // Subnormal alignment: shift right by 1 - e, capped at the quotient width.
  always_comb begin
    shift_full = 10'sd1 - e_r;
    sh_sat     = (shift_full > 10'sd27) ? 5'd27 : shift_full[4:0];
    quo_dn     = quo_r >> sh_sat;
    lost_mask  = ~({QW{1'b1}} << sh_sat);
    lost       = |(quo_r & lost_mask);
  end

  // Round and pack; a fraction carry rolls into the exponent field naturally.
  always_comb begin
    inc     = rne_inc(quo_r[3], quo_r[2], quo_r[1], quo_r[0] | sticky_r);
    sum     = {e_r, quo_r[25:3]} + {32'd0, inc};
    ovf     = (sum[32:23] >= 10'd255);
    round_q = ovf ? {sign_r, EXP_MAX, 23'd0} : {sign_r, sum[30:0]};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Next-state sequencing; busy covers every state except IDLE.
  always_comb begin
    next_state = state;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (start) next_state = UNPACK;
      UNPACK:  next_state = DIV;
      DIV:     if (cnt_r == 5'd0) next_state = DENORM;
      DENORM:  next_state = ROUND;
      ROUND:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath registers and the registered result / done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r           <= '0;
      b_r           <= '0;
      sign_r        <= 1'b0;
      e_r           <= '0;
      mb_r          <= '0;
      rem_r         <= '0;
      quo_r         <= '0;
      cnt_r         <= '0;
      sticky_r      <= 1'b0;
      special_r     <= 1'b0;
      special_q_r   <= '0;
      special_dbz_r <= 1'b0;
      q             <= '0;
      done          <= 1'b0;
      div_by_zero   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r <= a;
            b_r <= b;
          end
        end
        UNPACK: begin
          sign_r        <= sign_w;
          e_r           <= eff_a - eff_b + 10'sd127;
          mb_r          <= sig_b;
          rem_r         <= {2'b00, sig_a};
          quo_r         <= '0;
          cnt_r         <= 5'd26;
          sticky_r      <= 1'b0;
          special_r     <= spec_hit;
          special_q_r   <= spec_q;
          special_dbz_r <= spec_dbz;
        end
        DIV: begin
          rem_r <= rem_sub << 1;
          if (cnt_r == 5'd0) begin
            sticky_r <= |rem_sub;
            if (!quo_step[QW-1]) begin
              quo_r <= {quo_step[QW-2:0], 1'b0};
              e_r   <= e_r - 10'sd1;
            end else begin
              quo_r <= quo_step;
            end
          end else begin
            quo_r <= quo_step;
            cnt_r <= cnt_r - 5'd1;
          end
        end
        DENORM: begin
          if (e_r <= 10'sd0) begin
            quo_r    <= quo_dn;
            sticky_r <= sticky_r | lost;
            e_r      <= '0;
          end
        end
        ROUND: begin
          q           <= special_r ? special_q_r : round_q;
          div_by_zero <= special_r & special_dbz_r;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
